// File: rtl/hit_frame_counter_if.sv
// Frame-count result channel plus the serial bit/hit inputs of hit_frame_counter.
// master drives the stream and consumes results; slave is the counter itself.
interface hit_frame_counter_if #(
    parameter int CW = 5
);
    logic          bit_en;
    logic          hit;
    logic          clr;
    logic          cnt_ready;
    logic [CW-1:0] cnt_data;
    logic          cnt_valid;
    logic          ovf;

    modport master (
        output bit_en, hit, clr, cnt_ready,
        input  cnt_data, cnt_valid, ovf
    );

    modport slave (
        input  bit_en, hit, clr, cnt_ready,
        output cnt_data, cnt_valid, ovf
    );
endinterface

// File: rtl/hit_frame_counter.sv
// Counts detector hits over FRAME_LEN qualified bits and hands the saturated count
// to a one-deep valid/ready register; closes that find it occupied are dropped into ovf.
//
// state | meaning
// EMPTY | no unaccepted result; cnt_valid low
// FULL  | cnt_data holds a result awaiting cnt_ready
module hit_frame_counter #(
    parameter int FRAME_LEN = 16,
    parameter int CW        = 5
) (
    input  logic               clk,
    input  logic               rst,
    hit_frame_counter_if.slave bus
);
    localparam int              BW   = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0]   LAST = BW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]   MAX  = '1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] acc;
    logic [CW-1:0] acc_sat;
    logic [CW:0]   sum;
    logic [CW-1:0] data_q;
    logic          ovf_q;
    logic          take;
    logic          close;
    logic          load;
    logic          drop;

    // clr outranks bit_en, so a cleared cycle can never close a frame
    assign take    = bus.bit_en & ~bus.clr;
    assign close   = take & (bit_cnt == LAST);
    assign sum     = {1'b0, acc} + {{CW{1'b0}}, bus.hit};
    assign acc_sat = sum[CW] ? MAX : sum[CW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else if (bus.clr) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else if (bus.bit_en) begin
            if (close) begin
                bit_cnt <= '0;
                acc     <= '0;
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
                acc     <= acc_sat;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (close) begin
                    state_nxt = FULL;
                    load      = 1'b1;
                end
            end
            FULL: begin
                if (close) begin
                    // accepting in the same cycle frees the slot for the new result
                    if (bus.cnt_ready) load = 1'b1;
                    else               drop = 1'b1;
                end else if (bus.cnt_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) data_q <= acc_sat;
            if (drop) ovf_q  <= 1'b1;
        end
    end

    assign bus.cnt_valid = (state == FULL);
    assign bus.cnt_data  = data_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_hit_frame_counter.sv
// Bench for hit_frame_counter: a CW=5 and a CW=3 instance share one stimulus stream;
// a frame-level reference model feeds per-instance result queues popped by a monitor.
module tb_hit_frame_counter;
    localparam int FL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_en = 1'b0, hit = 1'b0, clr = 1'b0, cnt_ready = 1'b0;

    always #5 clk = ~clk;

    hit_frame_counter_if #(.CW(5)) if5 ();
    hit_frame_counter_if #(.CW(3)) if3 ();

    assign if5.bit_en = bit_en;
    assign if5.hit = hit;
    assign if5.clr = clr;
    assign if5.cnt_ready = cnt_ready;
    assign if3.bit_en = bit_en;
    assign if3.hit = hit;
    assign if3.clr = clr;
    assign if3.cnt_ready = cnt_ready;

    hit_frame_counter #(.FRAME_LEN(FL), .CW(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));
    hit_frame_counter #(.FRAME_LEN(FL), .CW(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    int n_tests = 0;
    int n_fail  = 0;

    int q5[$];
    int q3[$];
    int m_bits = 0;
    int m_hits = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT shows a result but none is expected at %0t", name, $time);
    endtask

    // Frame-level view: count qualified bits and hits, deliver min(hits, 2^CW-1) per frame.
    task automatic model_commit(input bit be, input bit h, input bit c, input bit r);
        bit closed = 1'b0;
        int res = 0;
        if (c) begin
            m_bits = 0;
            m_hits = 0;
        end else if (be) begin
            m_hits += int'(h);
            m_bits++;
            if (m_bits == FL) begin
                closed = 1'b1;
                res = m_hits;
                m_bits = 0;
                m_hits = 0;
            end
        end
        if (closed) begin
            if (!m_full || r) begin
                q5.push_back(res > 31 ? 31 : res);
                q3.push_back(res > 7 ? 7 : res);
                m_full = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_full && r) begin
            m_full = 1'b0;
        end
    endtask

    task automatic step(input bit be, input bit h, input bit c, input bit r);
        bit_en = be;
        hit = h;
        clr = c;
        cnt_ready = r;
        @(posedge clk);
        #1;
        model_commit(be, h, c, r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic frame(input logic [FL-1:0] mask, input bit r_last, input bit r_other);
        for (int i = 0; i < FL; i++)
            step(1'b1, mask[i], 1'b0, (i == FL - 1) ? r_last : r_other);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        #1;
        q5.delete();
        q3.delete();
        m_bits = 0;
        m_hits = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        chk("rst_data5", int'(if5.cnt_data), 0);
        chk("rst_valid5", int'(if5.cnt_valid), 0);
        chk("rst_ovf5", int'(if5.ovf), 0);
        chk("rst_data3", int'(if3.cnt_data), 0);
        chk("rst_valid3", int'(if3.cnt_valid), 0);
        chk("rst_ovf3", int'(if3.ovf), 0);
        for (int i = 0; i < cycles; i++) begin
            bit_en = 1'($urandom);
            hit = 1'($urandom);
            clr = 1'($urandom);
            cnt_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bit_en = 1'b0;
        hit = 1'b0;
        clr = 1'b0;
        cnt_ready = 1'b0;
        rst = 1'b1;
    endtask

    // Monitor: outputs are sampled mid-cycle; a result is consumed when valid and ready meet.
    always @(negedge clk) begin
        chk("valid5", int'(if5.cnt_valid), int'(m_full));
        chk("valid3", int'(if3.cnt_valid), int'(m_full));
        chk("ovf5", int'(if5.ovf), int'(m_ovf));
        chk("ovf3", int'(if3.ovf), int'(m_ovf));
        if (if5.cnt_valid === 1'b1) begin
            if (q5.size() == 0) fail_now("data5_unexpected");
            else begin
                chk("data5", int'(if5.cnt_data), q5[0]);
                if (cnt_ready) void'(q5.pop_front());
            end
        end
        if (if3.cnt_valid === 1'b1) begin
            if (q3.size() == 0) fail_now("data3_unexpected");
            else begin
                chk("data3", int'(if3.cnt_data), q3[0]);
                if (cnt_ready) void'(q3.pop_front());
            end
        end
    end

    initial begin
        #2;
        do_reset(5);
        idle(10, 1'b0);
        chk("post_rst_valid", int'(if5.cnt_valid), 0);

        // basic count: hits on bits 4 and 9, held under backpressure
        frame(16'h0210, 1'b0, 1'b0);
        chk("basic_valid", int'(if5.cnt_valid), 1);
        chk("basic_data", int'(if5.cnt_data), 2);
        idle(3, 1'b0);
        chk("basic_hold", int'(if5.cnt_data), 2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_accept", int'(if5.cnt_valid), 0);

        // gated bits: hits only when bit_en is low
        for (int i = 0; i < 32; i++) step(i % 2 == 0, i % 2 == 1, 1'b0, 1'b0);
        chk("gated_valid", int'(if5.cnt_valid), 1);
        chk("gated_data", int'(if5.cnt_data), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // backpressure and drop
        frame(16'h0007, 1'b0, 1'b0);
        frame(16'h001F, 1'b0, 1'b0);
        chk("drop_data", int'(if5.cnt_data), 3);
        chk("drop_ovf", int'(if5.ovf), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drop_accept", int'(if5.cnt_valid), 0);
        chk("drop_ovf_sticky", int'(if5.ovf), 1);

        // accept and load on the same edge
        do_reset(3);
        frame(16'h0700, 1'b0, 1'b0);
        frame(16'h0020, 1'b1, 1'b0);
        chk("acc_load_valid", int'(if5.cnt_valid), 1);
        chk("acc_load_data", int'(if5.cnt_data), 1);
        chk("acc_load_ovf", int'(if5.ovf), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // saturation
        frame(16'hFFFF, 1'b1, 1'b1);
        chk("sat_data3", int'(if3.cnt_data), 7);
        chk("sat_data5", int'(if5.cnt_data), 16);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // clear at frame bit 7 after 4 hits
        for (int i = 0; i < 7; i++) step(1'b1, i < 4, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        frame(16'h8001, 1'b1, 1'b1);
        chk("clr_data5", int'(if5.cnt_data), 2);
        chk("clr_data3", int'(if3.cnt_data), 2);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // async reset mid-frame with a result pending
        frame(16'h0003, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(2);
        frame(16'h0100, 1'b0, 1'b0);
        chk("rst_restart_data", int'(if5.cnt_data), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // throughput with cnt_ready tied high
        for (int i = 0; i < 4 * FL; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1);
        chk("thru_no_ovf", int'(if5.ovf), 0);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 2) != 0);

        idle(2, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
